// File: rtl/crt_ff_wr_ctl_pkg.sv
// Shared constants and helpers for the CRT fifo write-side controller.
package crt_ff_wr_ctl_pkg;

  localparam int unsigned FF_DEPTH    = 32;
  localparam int unsigned FF_AW       = 5;
  localparam int unsigned HALF_B_BASE = 16;

  // Last entry of each graphics half.
  localparam int unsigned GR_A_END = 15;
  localparam int unsigned GR_B_END = 31;

  // Text segment ends: low/high planes fill 8-entry segments in turn.
  localparam int unsigned TX_SEG0_END = 7;
  localparam int unsigned TX_SEG1_END = 15;
  localparam int unsigned TX_SEG2_END = 23;
  localparam int unsigned TX_SEG3_END = 31;

  // Half enables on the RAM write port: [0] low half, [1] high half.
  localparam logic [1:0] BE_GR = 2'b11;
  localparam logic [1:0] BE_LO = 2'b01;
  localparam logic [1:0] BE_HI = 2'b10;

  // An "a" window owns entries 0..15 and a "b" window owns 16..31;
  // the counter MSB tells which half the write would land in.
  function automatic logic win_violation(input logic win_a, input logic win_b,
                                         input logic [FF_AW-1:0] cnt);
    return (win_a & cnt[FF_AW-1]) | (win_b & ~cnt[FF_AW-1]);
  endfunction

endpackage

// File: rtl/crt_ff_wr_ctl_if.sv
// Bus between the CRT fifo write state machine / memory return path and
// the write-side controller. The controller takes the slave modport.
interface crt_ff_wr_ctl_if
  import crt_ff_wr_ctl_pkg::*;
#(
  parameter int unsigned DATA_W = 32
);

  // Memory return and mode/window qualifiers.
  logic              crt_ff_write;
  logic [DATA_W-1:0] mem_rdata;
  logic              graphic_mode;
  logic              text_mode;
  logic              sync_crt_line_end;
  logic              sync_pre_vde;
  logic              gr_ff_wra;
  logic              gr_ff_wrb;
  logic              tx_ff_wra_low;
  logic              tx_ff_wra_high;
  logic              tx_ff_wrb_low;
  logic              tx_ff_wrb_high;

  // RAM write port.
  logic              ff_wr_en;
  logic [FF_AW-1:0]  ff_wr_addr;
  logic [1:0]        ff_wr_be;
  logic [DATA_W-1:0] ff_wr_data;

  // Boundary strobes back to the write state machine and flag logic.
  logic              crt_fwr0;
  logic              crt_fwr15;
  logic              crt_fwr16;
  logic              crt_fwr31;
  logic              crt_fwr0_low;
  logic              crt_fwr7_low;
  logic              crt_fwr15_low;
  logic              crt_fwr16_low;
  logic              crt_fwr23_low;
  logic              crt_fwr31_low;
  logic              crt_fwr7_high;
  logic              crt_fwr15_high;
  logic              crt_fwr23_high;
  logic              crt_fwr31_high;

  logic              wr_ovf_err;

  modport slave (
    input  crt_ff_write, mem_rdata, graphic_mode, text_mode,
    input  sync_crt_line_end, sync_pre_vde,
    input  gr_ff_wra, gr_ff_wrb,
    input  tx_ff_wra_low, tx_ff_wra_high, tx_ff_wrb_low, tx_ff_wrb_high,
    output ff_wr_en, ff_wr_addr, ff_wr_be, ff_wr_data,
    output crt_fwr0, crt_fwr15, crt_fwr16, crt_fwr31,
    output crt_fwr0_low, crt_fwr7_low, crt_fwr15_low, crt_fwr16_low,
    output crt_fwr23_low, crt_fwr31_low,
    output crt_fwr7_high, crt_fwr15_high, crt_fwr23_high, crt_fwr31_high,
    output wr_ovf_err
  );

  modport master (
    output crt_ff_write, mem_rdata, graphic_mode, text_mode,
    output sync_crt_line_end, sync_pre_vde,
    output gr_ff_wra, gr_ff_wrb,
    output tx_ff_wra_low, tx_ff_wra_high, tx_ff_wrb_low, tx_ff_wrb_high,
    input  ff_wr_en, ff_wr_addr, ff_wr_be, ff_wr_data,
    input  crt_fwr0, crt_fwr15, crt_fwr16, crt_fwr31,
    input  crt_fwr0_low, crt_fwr7_low, crt_fwr15_low, crt_fwr16_low,
    input  crt_fwr23_low, crt_fwr31_low,
    input  crt_fwr7_high, crt_fwr15_high, crt_fwr23_high, crt_fwr31_high,
    input  wr_ovf_err
  );

endinterface

// File: rtl/crt_ff_wr_cnt.sv
// 5-bit fifo write-address counter with synchronous clear (priority over
// advance), natural 31 -> 0 wrap and a one-hot equality decode of its value.
module crt_ff_wr_cnt
  import crt_ff_wr_ctl_pkg::*;
(
  input  logic                mem_clk,
  input  logic                hreset_n,
  input  logic                i_clr,
  input  logic                i_adv,
  output logic [FF_AW-1:0]    o_cnt,
  output logic [FF_DEPTH-1:0] o_eq
);

  logic [FF_AW-1:0] r_cnt;

  // Counter state: clear wins over advance; wrap falls out of the width.
  always_ff @(posedge mem_clk or negedge hreset_n) begin
    if (!hreset_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_adv) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Equality decode bank: bit N is set while the counter holds N.
  always_comb begin
    o_eq        = '0;
    o_eq[r_cnt] = 1'b1;
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/crt_ff_wr_ctl.sv
// Write-side datapath and address generator for the 32-entry CRT fifo.
// Qualifies returned memory data against the write windows, drives the
// registered RAM write port and decodes the boundary strobes.
module crt_ff_wr_ctl
  import crt_ff_wr_ctl_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic           mem_clk,
  input  logic           hreset_n,
  crt_ff_wr_ctl_if.slave bus
);

  if ((DATA_W % 2) != 0) begin : g_bad_width
    $error("DATA_W must be even");
  end

  logic                w_gwr;
  logic                w_twl;
  logic                w_twh_raw;
  logic                w_twh;
  logic                w_any;
  logic                w_clr;
  logic                w_lo_adv;
  logic                w_ovf;
  logic [FF_AW-1:0]    w_lo_cnt;
  logic [FF_AW-1:0]    w_hi_cnt;
  logic [FF_DEPTH-1:0] w_lo_eq;
  logic [FF_DEPTH-1:0] w_hi_eq;
  logic [FF_AW-1:0]    w_addr;
  logic [1:0]          w_be;

  logic                r_en;
  logic [FF_AW-1:0]    r_addr;
  logic [1:0]          r_be;
  logic [DATA_W-1:0]   r_data;
  logic                r_ovf;

  // Write qualification: graphics mode shadows text mode.
  always_comb begin
    w_gwr     = bus.crt_ff_write & bus.graphic_mode & (bus.gr_ff_wra | bus.gr_ff_wrb);
    w_twl     = bus.crt_ff_write & bus.text_mode & ~bus.graphic_mode &
                (bus.tx_ff_wra_low | bus.tx_ff_wrb_low);
    w_twh_raw = bus.crt_ff_write & bus.text_mode & ~bus.graphic_mode &
                (bus.tx_ff_wra_high | bus.tx_ff_wrb_high);
    // Low and high windows together is an SM fault: the low write wins.
    w_twh     = w_twh_raw & ~w_twl;
    w_any     = w_gwr | w_twl | w_twh;
    w_lo_adv  = w_gwr | w_twl;
    w_clr     = bus.sync_crt_line_end | bus.sync_pre_vde;
  end

  crt_ff_wr_cnt u_lo_cnt (
    .mem_clk  (mem_clk),
    .hreset_n (hreset_n),
    .i_clr    (w_clr),
    .i_adv    (w_lo_adv),
    .o_cnt    (w_lo_cnt),
    .o_eq     (w_lo_eq)
  );

  crt_ff_wr_cnt u_hi_cnt (
    .mem_clk  (mem_clk),
    .hreset_n (hreset_n),
    .i_clr    (w_clr),
    .i_adv    (w_twh),
    .o_cnt    (w_hi_cnt),
    .o_eq     (w_hi_eq)
  );

  // Port address / half-enable selection for the qualifying write.
  always_comb begin
    w_addr = w_hi_cnt;
    w_be   = BE_HI;
    if (w_gwr) begin
      w_addr = w_lo_cnt;
      w_be   = BE_GR;
    end else if (w_twl) begin
      w_addr = w_lo_cnt;
      w_be   = BE_LO;
    end
  end

  // Range check of each qualified write against its window's half.
  always_comb begin
    w_ovf = (w_gwr & win_violation(bus.gr_ff_wra, bus.gr_ff_wrb, w_lo_cnt)) |
            (w_twl & win_violation(bus.tx_ff_wra_low, bus.tx_ff_wrb_low, w_lo_cnt)) |
            (w_twh & win_violation(bus.tx_ff_wra_high, bus.tx_ff_wrb_high, w_hi_cnt)) |
            (w_twl & w_twh_raw);
  end

  // Write-port pipeline: one cycle behind qualification; holds when idle.
  always_ff @(posedge mem_clk or negedge hreset_n) begin
    if (!hreset_n) begin
      r_en   <= 1'b0;
      r_addr <= '0;
      r_be   <= '0;
      r_data <= '0;
    end else begin
      r_en <= w_any;
      if (w_any) begin
        r_addr <= w_addr;
        r_be   <= w_be;
        r_data <= bus.mem_rdata;
      end
    end
  end

  // Sticky overflow error, cleared only by reset.
  always_ff @(posedge mem_clk or negedge hreset_n) begin
    if (!hreset_n) begin
      r_ovf <= 1'b0;
    end else if (w_ovf) begin
      r_ovf <= 1'b1;
    end
  end

  assign bus.ff_wr_en   = r_en;
  assign bus.ff_wr_addr = r_addr;
  assign bus.ff_wr_be   = r_be;
  assign bus.ff_wr_data = r_data;
  assign bus.wr_ovf_err = r_ovf;

  // Boundary strobes fire with the write at that entry, not after it.
  assign bus.crt_fwr0       = w_gwr & w_lo_eq[0];
  assign bus.crt_fwr15      = w_gwr & w_lo_eq[GR_A_END];
  assign bus.crt_fwr16      = w_gwr & w_lo_eq[HALF_B_BASE];
  assign bus.crt_fwr31      = w_gwr & w_lo_eq[GR_B_END];

  assign bus.crt_fwr0_low   = w_twl & w_lo_eq[0];
  assign bus.crt_fwr7_low   = w_twl & w_lo_eq[TX_SEG0_END];
  assign bus.crt_fwr15_low  = w_twl & w_lo_eq[TX_SEG1_END];
  assign bus.crt_fwr16_low  = w_twl & w_lo_eq[HALF_B_BASE];
  assign bus.crt_fwr23_low  = w_twl & w_lo_eq[TX_SEG2_END];
  assign bus.crt_fwr31_low  = w_twl & w_lo_eq[TX_SEG3_END];

  assign bus.crt_fwr7_high  = w_twh & w_hi_eq[TX_SEG0_END];
  assign bus.crt_fwr15_high = w_twh & w_hi_eq[TX_SEG1_END];
  assign bus.crt_fwr23_high = w_twh & w_hi_eq[TX_SEG2_END];
  assign bus.crt_fwr31_high = w_twh & w_hi_eq[TX_SEG3_END];

  // Only a few decode taps are strobed; the rest of each bank is spare.
  logic unused_eq;
  assign unused_eq = ^{w_lo_eq, w_hi_eq};

endmodule
